// File: rtl/addsub_chunked.sv
// rtl/addsub_chunked.sv - multi-cycle two's-complement adder/subtractor, CHUNK bits per clock
module addsub_chunked #(
    parameter int N     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         zero
);
    localparam int K  = N / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_op_a;
    logic [N-1:0]    r_op_b;
    logic [N-1:0]    r_acc;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    r_sum;
    logic            r_c_out;
    logic            r_ovf;
    logic            r_zero;

    int              w_lsb;
    logic [CHUNK-1:0] w_s;
    logic            w_c;
    logic [N-1:0]    w_acc_next;
    logic            w_last;
    logic            w_ovf;

    // One chunk of the ripple: the carry register links consecutive cycles.
    always_comb begin
        w_lsb      = int'(r_idx) * CHUNK;
        {w_c, w_s} = {1'b0, r_op_a[w_lsb +: CHUNK]} + {1'b0, r_op_b[w_lsb +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_carry};
        w_acc_next = r_acc;
        w_acc_next[w_lsb +: CHUNK] = w_s;
    end

    assign w_last = (r_idx == IW'(K - 1));
    assign w_ovf  = (r_op_a[N-1] == r_op_b[N-1]) && (w_acc_next[N-1] != r_op_a[N-1]);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && start) begin
                // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                r_op_a  <= a;
                r_op_b  <= sub ? ~b : b;
                r_carry <= sub;
                r_idx   <= '0;
                r_acc   <= '0;
            end else if (r_state == S_RUN) begin
                r_acc   <= w_acc_next;
                r_carry <= w_c;
                if (w_last) begin
                    r_idx   <= '0;
                    r_sum   <= w_acc_next;
                    r_c_out <= w_c;
                    r_ovf   <= w_ovf;
                    r_zero  <= (w_acc_next == '0);
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;
    assign zero  = r_zero;
endmodule

// File: tb/tb_addsub_chunked.sv
// tb/tb_addsub_chunked.sv - bench for addsub_chunked at CHUNK=4, 16 and 1
module tb_addsub_chunked;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                sub;
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic [2:0]          start;
    logic [2:0]          busy;
    logic [2:0]          done;
    logic [2:0]          c_out;
    logic [2:0]          ovf;
    logic [2:0]          zero;
    logic [2:0][N-1:0]   sum;

    int errors = 0;
    int checks = 0;

    int          kval [3] = '{4, 1, 16};
    logic [N-1:0] exp_sum [3];
    logic        exp_c [3];
    logic        exp_v [3];
    logic        exp_z [3];

    always #5 clk = ~clk;

    addsub_chunked #(.N(N), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b),
        .busy(busy[0]), .done(done[0]), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0]), .zero(zero[0])
    );
    addsub_chunked #(.N(N), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b),
        .busy(busy[1]), .done(done[1]), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1]), .zero(zero[1])
    );
    addsub_chunked #(.N(N), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b),
        .busy(busy[2]), .done(done[2]), .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2]), .zero(zero[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Signed and unsigned views of the true arithmetic result.
    task automatic ref_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic si,
                          output logic [N-1:0] rs, output logic rc, output logic rv, output logic rz);
        int sa, sb, r;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        if (si) begin
            r  = sa - sb;
            rs = ai - bi;
            rc = (ai >= bi);
        end else begin
            r  = sa + sb;
            rs = ai + bi;
            rc = ((int'(ai) + int'(bi)) > 65535);
        end
        rv = (r > 32767) || (r < -32768);
        rz = (rs == '0);
    endtask

    task automatic check_outputs(input int d, input string tag);
        check({tag, "_sum"},  32'(sum[d]),   32'(exp_sum[d]));
        check({tag, "_cout"}, 32'(c_out[d]), 32'(exp_c[d]));
        check({tag, "_ovf"},  32'(ovf[d]),   32'(exp_v[d]));
        check({tag, "_zero"}, 32'(zero[d]),  32'(exp_z[d]));
    endtask

    task automatic run_op(input int d, input logic [N-1:0] ai, input logic [N-1:0] bi, input logic si,
                          input string tag);
        logic [N-1:0] rs;
        logic rc, rv, rz;
        int lat;
        ref_op(ai, bi, si, rs, rc, rv, rz);
        @(negedge clk);
        a = ai; b = bi; sub = si; start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
        check({tag, "_busy_e0"}, 32'(busy[d]), 32'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done[d]) break;
            if (sum[d] !== exp_sum[d] || busy[d] !== 1'b1)
                check({tag, "_hold"}, {15'd0, busy[d], sum[d]}, {15'd0, 1'b1, exp_sum[d]});
        end
        check({tag, "_latency"}, 32'(lat), 32'(kval[d]));
        check({tag, "_done"}, {31'd0, done[d]}, 32'd1);
        check({tag, "_busy_done"}, {31'd0, busy[d]}, 32'd0);
        exp_sum[d] = rs; exp_c[d] = rc; exp_v[d] = rv; exp_z[d] = rz;
        check_outputs(d, tag);
        @(posedge clk); #1;
        check({tag, "_done_clear"}, {30'd0, busy[d], done[d]}, 32'd0);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = '0; sub = 1'b0; a = '0; b = '0;
        for (int d = 0; d < 3; d++) begin
            exp_sum[d] = '0; exp_c[d] = 1'b0; exp_v[d] = 1'b0; exp_z[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_flags", {28'd0, busy[d], done[d], c_out[d], ovf[d]}, 32'd0);
            check("reset_sum_zero", {15'd0, zero[d], sum[d]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            run_op(d, 16'h1234, 16'h0001, 1'b0, $sformatf("add_basic_k%0d", kval[d]));
            run_op(d, 16'h7FFF, 16'h0001, 1'b0, $sformatf("add_ovf_k%0d", kval[d]));
            run_op(d, 16'hFFFF, 16'h0001, 1'b0, $sformatf("add_wrap_k%0d", kval[d]));
            run_op(d, 16'h0005, 16'h0005, 1'b1, $sformatf("sub_eq_k%0d", kval[d]));
            run_op(d, 16'h0003, 16'h0005, 1'b1, $sformatf("sub_borrow_k%0d", kval[d]));
            run_op(d, 16'h8000, 16'h0001, 1'b1, $sformatf("sub_ovf_k%0d", kval[d]));
            run_op(d, 16'h0000, 16'h8000, 1'b1, $sformatf("sub_min_k%0d", kval[d]));
        end

        // A second start two cycles into RUN must be dropped without disturbing the operands.
        begin
            logic [N-1:0] rs;
            logic rc, rv, rz;
            ref_op(16'h0010, 16'h0020, 1'b0, rs, rc, rv, rz);
            @(negedge clk);
            a = 16'h0010; b = 16'h0020; sub = 1'b0; start[0] = 1'b1;
            @(posedge clk); #1;
            start[0] = 1'b0;
            @(posedge clk); #1;
            a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start[0] = 1'b1;
            @(posedge clk); #1;
            start[0] = 1'b0;
            ndone = 0;
            for (int i = 0; i < 12; i++) begin
                if (done[0]) begin
                    ndone++;
                    exp_sum[0] = rs; exp_c[0] = rc; exp_v[0] = rv; exp_z[0] = rz;
                    check_outputs(0, "ignored_start");
                end else if (sum[0] !== exp_sum[0]) begin
                    check("ignored_start_hold", 32'(sum[0]), 32'(exp_sum[0]));
                end
                @(posedge clk); #1;
            end
            check("ignored_start_done_count", 32'(ndone), 32'd1);
            check("ignored_start_idle", {31'd0, busy[0]}, 32'd0);
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_flags", {28'd0, busy[0], done[0], c_out[0], ovf[0]}, 32'd0);
        check("midrst_sum_zero", {15'd0, zero[0], sum[0]}, 32'd0);
        check("midrst_other_sum", {sum[1], sum[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            exp_sum[d] = '0; exp_c[d] = 1'b0; exp_v[d] = 1'b0; exp_z[d] = 1'b0;
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done[0] || busy[0]) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_op(0, 16'h0100, 16'h0001, 1'b1, "after_rst");

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                run_op(d, N'($urandom), N'($urandom), 1'($urandom), $sformatf("rand_k%0d_%0d", kval[d], i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
